wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port wb_valid, input, 1, pipeline WB stage holds a register write this cycle.
REQ-004 SHALL have port wb_addr, input, 5, pipeline destination register.
REQ-005 SHALL have port wb_data, input, `RegDataBus (32), pipeline write data (mem-or-ALU selected upstream).
REQ-006 SHALL have port lu_valid, input, 1, long-latency unit (mul/div) offers a result.
REQ-007 SHALL have port lu_addr, input, 5, long-latency destination register.
REQ-008 SHALL have port lu_data, input, `RegDataBus, long-latency result.
REQ-009 SHALL have port lu_ready, output, 1, arbiter accepts lu result this cycle.
REQ-010 SHALL have port rf_we, output, 1, register-file write enable (registered).
REQ-011 SHALL have port rf_waddr, output, 5, register-file write address (registered).
REQ-012 SHALL have port rf_wdata, output, `RegDataBus, register-file write data (registered).
REQ-013 SHALL have port stall_req, output, 1, request to hold the pipeline WB stage this cycle.

Function
REQ-014 SHALL buffer long-latency results in a 2-entry FIFO; push when lu_valid && lu_ready at rising clk.
REQ-015 SHALL drive lu_ready = !full (combinational); no push when full, even if a pop occurs that cycle.
REQ-016 SHALL grant the register-file port each cycle: stall_req=1 -> FIFO head; else wb_valid=1 -> pipeline; else FIFO nonempty -> FIFO head; else no grant.
REQ-017 SHALL register the granted address/data into rf_waddr/rf_wdata and set rf_we=1 on the next rising clk; latency 1 cycle from grant.
REQ-018 SHALL pop the FIFO head on the same edge it is registered to the outputs.
REQ-019 SHALL hold rf_we=0 and rf_waddr/rf_wdata at previous values when no grant.
REQ-020 SHALL suppress writes to address 0: granted entry consumed/popped normally, rf_we stays 0.
REQ-021 SHALL ignore wb_valid/wb_addr/wb_data in any cycle stall_req=1; the pipeline re-presents them next cycle.
REQ-022 SHALL wrap FIFO read/write pointers modulo 2; simultaneous push and pop at count 1 keeps count 1 and preserves order.
REQ-023 SHALL impose no ordering between the two sources for the same address; hazard unit prevents conflicts.
REQ-024 SHALL minimum lu-result-to-rf_we latency be 2 cycles (push edge, then grant edge).

Reset
REQ-025 SHALL on rst=1 clear FIFO (count 0, pointers 0), starvation counter 0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-026 SHALL drive lu_ready=1 and stall_req=0 while and after rst until new state dictates otherwise.
REQ-027 SHALL discard any buffered long-latency results on reset mid-operation; a push coincident with rst is dropped.

Configuration
REQ-028 SHALL, with WB_ARB_ANTISTARVE_EN defined, keep a 2-bit saturating counter: +1 each cycle FIFO nonempty and pipeline granted; cleared when FIFO head granted or FIFO empty.
REQ-029 SHALL, with WB_ARB_ANTISTARVE_EN defined, assert stall_req combinationally when counter==3 and FIFO nonempty.
REQ-030 SHALL, without WB_ARB_ANTISTARVE_EN, tie stall_req to 0, omit the counter; pipeline always wins.

Verification
REQ-031 SHALL test: wb_valid=1, addr 5, data 0x1234 one cycle, FIFO empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-032 SHALL test: lu push addr 8 data 0xAA with wb_valid=0 -> rf_we=1, addr 8, data 0xAA 2 cycles after push.
REQ-033 SHALL test: two lu pushes while wb_valid=1 continuously -> lu_ready=0 after 2nd push; third offer held until pop.
REQ-034 SHALL test (macro on): FIFO nonempty, wb_valid=1 for 4 cycles -> stall_req=1 in 4th cycle, FIFO head written next cycle; stall_req then 0.
REQ-035 SHALL test: wb_valid=1 addr 0 data 0xFFFF -> rf_we stays 0; FIFO entry to addr 0 popped with rf_we=0.
REQ-036 SHALL test: rst asserted with FIFO holding 2 entries -> next cycle rf_we=0, lu_ready=1, no stale entry ever written.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of signals between the write-back stage, the long-latency unit
// (mul/div) and the register-file write port around wb_port_arbiter.
// slave  : the arbiter's view.
// master : the view of the surrounding pipeline or a testbench.
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

interface wb_port_arbiter_if;
  // Pipeline write-back stage
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [`RegDataBus] wb_data;
  // Long-latency unit result offer
  logic              lu_valid;
  logic [4:0]        lu_addr;
  logic [`RegDataBus] lu_data;
  logic              lu_ready;
  // Register-file write port and pipeline hold request
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [`RegDataBus] rf_wdata;
  logic              stall_req;

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output stall_req
  );

  modport master (
    output wb_valid, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The pipeline WB stage and a long-latency unit both write the register
// file. Long-latency results are buffered in a 2-entry FIFO. The pipeline
// normally wins, and the FIFO drains in cycles with no pipeline write.
// Optional macro WB_ARB_ANTISTARVE_EN adds a starvation counter. After
// three consecutive pipeline wins over a non-empty FIFO, the arbiter raises
// stall_req and writes the FIFO head instead.
// Writes to address 0 are consumed without asserting rf_we. rf_waddr and
// rf_wdata then keep the last real write.
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

module wb_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } grant_e;

  // FIFO storage and control
  logic [4:0]         fifo_addr_q [2];
  logic [`RegDataBus] fifo_data_q [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q,  count_d;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  // Arbitration
  grant_e             grant;
  logic [4:0]         gnt_addr;
  logic [`RegDataBus] gnt_data;
  logic               stall;

  // Registered register-file port
  logic               rf_we_q,    rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [`RegDataBus] rf_wdata_q, rf_wdata_d;

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);

`ifdef WB_ARB_ANTISTARVE_EN
  logic [1:0] starve_q, starve_d;
  assign stall = !rst && (starve_q == 2'd3) && !fifo_empty;
`else
  assign stall = 1'b0;
`endif

  // lu_ready is forced high during reset. A push in that cycle is still
  // dropped, because reset clears the FIFO on the same edge.
  assign bus.lu_ready  = rst || !fifo_full;
  assign bus.stall_req = stall;
  assign push          = bus.lu_valid && !fifo_full && !rst;
  assign pop           = (grant == GNT_FIFO);

  // Grant priority: forced FIFO drain, then pipeline, then FIFO when idle.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant    = GNT_NONE;
    gnt_addr = '0;
    gnt_data = '0;
    if (stall || (!bus.wb_valid && !fifo_empty)) begin
      grant    = GNT_FIFO;
      gnt_addr = fifo_addr_q[rd_ptr_q];
      gnt_data = fifo_data_q[rd_ptr_q];
    end else if (bus.wb_valid) begin
      grant    = GNT_PIPE;
      gnt_addr = bus.wb_addr;
      gnt_data = bus.wb_data;
    end
  end

  // FIFO pointer and occupancy next state.
  // The pointers are 1 bit wide, so they wrap modulo 2.
  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Register-file port next state. Address 0 is consumed but never written.
  always_comb begin
    rf_we_d    = (grant != GNT_NONE) && (gnt_addr != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
  end

`ifdef WB_ARB_ANTISTARVE_EN
  // Starvation counter: counts pipeline wins over a waiting FIFO entry,
  // saturating at 3.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = 2'd0;
    end else if ((grant == GNT_PIPE) && (starve_q != 2'd3)) begin
      starve_d = starve_q + 2'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Control and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO payload storage, written on push.
  // NOTE: the storage array has no reset. Count and pointers guard every read, so clearing the entries would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.lu_addr;
      fifo_data_q[wr_ptr_q] <= bus.lu_data;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule
